// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder: FSM encoding, digit width
// and the decimal-correction constants.
package bcd_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [4:0] BCD_MAX_DIGIT  = 5'd9;
    localparam logic [4:0] BCD_CORRECTION = 5'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A nibble outside 0..9 is not a legal BCD digit.
    function automatic logic bcd_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return {1'b0, d} > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Request/result bundle for the serial BCD adder; master drives operands and
// start, slave returns status and the packed BCD result.
interface bcd_serial_adder_ctrl_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                          start;
    logic [BCD_DIGIT_W*DIGITS-1:0] a;
    logic [BCD_DIGIT_W*DIGITS-1:0] b;
    logic                          cin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] sum;
    logic                          cout;
    logic                          err;

    modport master (output start, a, b, cin, input busy, done, sum, cout, err);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_digit_add.sv
// One decimal digit of addition: binary sum of two BCD nibbles plus carry,
// corrected by +6 whenever the binary result passes 9.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   cout
);
    logic [BCD_DIGIT_W:0]   s;
    logic [BCD_DIGIT_W-1:0] adj;

    assign s     = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
    // Only the low nibble survives the correction, which gives the mod-16 wrap.
    assign adj   = s[BCD_DIGIT_W-1:0] + BCD_CORRECTION[BCD_DIGIT_W-1:0];
    assign cout  = s > BCD_MAX_DIGIT;
    assign digit = cout ? adj : s[BCD_DIGIT_W-1:0];
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Serial packed-BCD adder: one shared digit adder walks the operands LSD first.
// Define BCD_DIGIT_CHECK_EN to build the sticky invalid-digit flag on err.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          err
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                        state_q, state_d;
    logic [BCD_DIGIT_W*DIGITS-1:0] a_q, b_q;
    logic                          c_q;
    logic [IW-1:0]                 idx;
    logic [BCD_DIGIT_W-1:0]        a_i, b_i, d_sum;
    logic                          d_cout, last;

    assign a_i  = a_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign b_i  = b_q[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
    assign last = (idx == IW'(DIGITS-1));

    bcd_digit_add u_dig (
        .a     (a_i),
        .b     (b_i),
        .cin   (c_q),
        .digit (d_sum),
        .cout  (d_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                busy    = 1'b1;
                state_d = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_q   <= a;
                    b_q   <= b;
                    c_q   <= cin;
`ifdef BCD_DIGIT_CHECK_EN
                    err_q <= 1'b0;
`endif
                end
                LOAD: begin
                    idx  <= '0;
                    sum  <= '0;
                    cout <= 1'b0;
                end
                ADD: begin
                    sum[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= d_sum;
                    c_q <= d_cout;
                    idx <= idx + 1'b1;
                    if (last) cout <= d_cout;
`ifdef BCD_DIGIT_CHECK_EN
                    if (bcd_invalid(a_i) || bcd_invalid(b_i)) err_q <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for the serial BCD adder: stimulus pushes expected results into
// a scoreboard that a separate negedge monitor drains whenever done pulses.
module tb_bcd_serial_adder_ctrl;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    typedef struct {
        string        name;
        logic [31:0]  act;
        logic [31:0]  exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst_n;

    bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bif ();

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bif.start),
        .a     (bif.a),
        .b     (bif.b),
        .cin   (bif.cin),
        .busy  (bif.busy),
        .done  (bif.done),
        .sum   (bif.sum),
        .cout  (bif.cout),
        .err   (bif.err)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    chk_t chk_q[$];
    int   nvec = 0;
    int   nmis = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   done_cnt = 0;
    int   bcnt = 0;

`ifdef BCD_DIGIT_CHECK_EN
    localparam logic CHK_ERR = 1'b1;
`else
    localparam logic CHK_ERR = 1'b0;
`endif

    initial forever @(posedge clk) cyc++;

    function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: the only process that steps the counters.
    initial forever begin
        @(negedge clk);
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            compare(c.name, c.act, c.exp);
        end
        if (!rst_n) begin
            bcnt = 0;
        end else begin
            if (bif.busy) bcnt++;
            if (bif.done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    compare("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    compare("sum",  32'(bif.sum),  32'(e.sum));
                    compare("cout", 32'(bif.cout), 32'(e.cout));
                    compare("err",  32'(bif.err),  32'(e.err));
                    // done is set by edge DIGITS+1 after accept, so edge DIGITS+2 samples it high
                    compare("done_latency", 32'(cyc - accept_cyc), 32'(DIGITS + 2 - 1));
                    compare("busy_cycles",  32'(bcnt), 32'(DIGITS + 1));
                    compare("busy_at_done", 32'(bif.busy), 32'd0);
                end
                bcnt = 0;
            end
        end
    end

    task automatic push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name; c.act = act; c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        bif.a = av; bif.b = bv; bif.cin = cv; bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start  = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic wait_done(input int base);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base) seen = 1;
        end
        if (!seen) push_chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input logic [W-1:0] es, input logic ec, input logic ee);
        exp_t e;
        int   base;
        e.sum = es; e.cout = ec; e.err = ee;
        sb_q.push_back(e);
        base = done_cnt;
        issue(av, bv, cv);
        wait_done(base);
        // result must hold in IDLE while inputs wander
        bif.a = 16'h7777; bif.b = 16'h2222;
        repeat (2) @(posedge clk);
        #1;
        push_chk("sum_hold", 32'(bif.sum), 32'(es));
    endtask

    initial begin
        int base;
        exp_t e;
        rst_n = 1'b0;
        bif.start = 1'b0; bif.a = '0; bif.b = '0; bif.cin = 1'b0;
        #12;
        push_chk("rst_flags", {28'd0, bif.busy, bif.done, bif.cout, bif.err}, 32'd0);
        push_chk("rst_sum", 32'(bif.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        run(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        run(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        // start re-pulsed mid-ADD with new operands must be ignored
        e.sum = 16'h6912; e.cout = 1'b0; e.err = 1'b0;
        sb_q.push_back(e);
        base = done_cnt;
        issue(16'h1234, 16'h5678, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bif.a = 16'h1111; bif.b = 16'h1111; bif.cin = 1'b1; bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        wait_done(base);
        repeat (6) @(negedge clk);
        #1;
        push_chk("one_done", 32'(done_cnt - base), 32'd1);

        // reset during the second ADD cycle
        issue(16'h1234, 16'h5678, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_chk("midrst_flags", {28'd0, bif.busy, bif.done, bif.cout, bif.err}, 32'd0);
        push_chk("midrst_sum", 32'(bif.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        // invalid digit: A+0 corrects to 0 with carry into the next digit
        run(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, CHK_ERR);
        run(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        push_chk("sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
